// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests, issues flush/redirect
// on exceptions and eret, runs a stall watchdog and a saturating stall-cycle counter.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
    parameter logic [31:0] TIMEOUT_VECTOR = 32'h0000_0040,
    parameter int unsigned TIMEOUT        = 1024,
    parameter int unsigned CNT_W          = 16,
    parameter logic [31:0] PERF_PRELOAD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] except_type_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        clr_perf_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        timeout_o,
    output logic [31:0] stall_cycles_o
);

    localparam int unsigned STALL_W   = 6;
    localparam int unsigned PERF_W    = 32;
    localparam logic [31:0]        ERET_CODE = 32'h0000_000e;
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_FE   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [CNT_W-1:0]   WD_LAST    = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_STALL = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_wd_cnt;
    logic [CNT_W-1:0]    w_wd_nxt;
    logic [PERF_W-1:0]   r_stall_cycles;
    logic [STALL_W-1:0]  w_stall_req;
    logic                w_req_any;
    logic                w_exc_accept;
    logic                w_is_eret;
    logic                w_wd_expired;

    // Highest-numbered requesting stage decides how far back the freeze reaches
    always_comb begin
        w_stall_req = STALL_NONE;
        if (stallreq_from_mem) begin
            w_stall_req = STALL_MEM;
        end else if (stallreq_from_ex) begin
            w_stall_req = STALL_EX;
        end else if (stallreq_from_id || stallreq_from_if) begin
            w_stall_req = STALL_FE;
        end
    end

    assign w_req_any    = stallreq_from_if | stallreq_from_id | stallreq_from_ex | stallreq_from_mem;
    // A frozen MEM stage keeps the exception pending until it can retire
    assign w_exc_accept = (except_type_i != 32'h0) && !stallreq_from_mem;
    assign w_is_eret    = (except_type_i == ERET_CODE);
    assign w_wd_expired = (TIMEOUT != 0) && (r_wd_cnt == WD_LAST);

    // Next-state and zero-latency pipeline controls
    always_comb begin
        w_state_nxt = r_state;
        w_wd_nxt    = r_wd_cnt;
        stall       = STALL_NONE;
        flush       = 1'b0;
        new_pc      = 32'h0;
        timeout_o   = 1'b0;
        if (rst) begin
            w_state_nxt = S_RUN;
            w_wd_nxt    = '0;
        end else begin
            case (r_state)
                S_RUN, S_STALL: begin
                    if (w_exc_accept) begin
                        flush       = 1'b1;
                        new_pc      = w_is_eret ? cp0_epc_i : EXC_VECTOR;
                        w_state_nxt = S_FLUSH;
                        w_wd_nxt    = '0;
                    end else if (!w_req_any) begin
                        w_state_nxt = S_RUN;
                        w_wd_nxt    = '0;
                    end else if ((r_state == S_STALL) && w_wd_expired) begin
                        flush       = 1'b1;
                        new_pc      = TIMEOUT_VECTOR;
                        timeout_o   = 1'b1;
                        w_state_nxt = S_FLUSH;
                        w_wd_nxt    = '0;
                    end else begin
                        stall       = w_stall_req;
                        w_state_nxt = S_STALL;
                        w_wd_nxt    = r_wd_cnt + CNT_W'(1);
                    end
                end
                S_FLUSH: begin
                    // Downstream stages hold bubbles now; only fetch can still be waiting
                    if (stallreq_from_if) begin
                        stall       = STALL_FE;
                        w_state_nxt = S_STALL;
                        w_wd_nxt    = r_wd_cnt + CNT_W'(1);
                    end else begin
                        w_state_nxt = S_RUN;
                        w_wd_nxt    = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                    w_wd_nxt    = '0;
                end
            endcase
        end
    end

    // State, watchdog and saturating perf counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_RUN;
            r_wd_cnt       <= '0;
            r_stall_cycles <= PERF_PRELOAD;
        end else begin
            r_state  <= w_state_nxt;
            r_wd_cnt <= w_wd_nxt;
            if (clr_perf_i) begin
                r_stall_cycles <= '0;
            end else if (stall[0] && (r_stall_cycles != {PERF_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + PERF_W'(1);
            end
        end
    end

    assign stall_cycles_o = r_stall_cycles;

endmodule
